// File: rtl/ecpri_tx_resp_if.sv
// Byte-wide response frame stream with first/last-byte markers and ready/valid handshake.
interface ecpri_tx_resp_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_sop;
    logic                  tx_eop;
    logic                  tx_ready;

    modport master (output tx_data, output tx_valid, output tx_sop, output tx_eop, input tx_ready);
    modport slave  (input tx_data, input tx_valid, input tx_sop, input tx_eop, output tx_ready);
endinterface

// File: rtl/ecpri_tx_resp.sv
// eCPRI RMA response framer: 16 header bytes then read data; byte 0 one cycle after the request, data 1 byte/3 cycles.
// Stalls hold the presented byte stable; requests arriving while busy are dropped with a resp_drop pulse.
module ecpri_tx_resp #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  send_write_resp,
    input  logic                  send_read_resp,
    input  logic [DATA_WIDTH-1:0] resp_payload_len,
    input  logic [7:0]            resp_rma_id,
    input  logic [15:0]           resp_elem_id,
    input  logic [ADDR_WIDTH-1:0] resp_addr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_oe,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    ecpri_tx_resp_if.master       tx,
    output logic                  busy,
    output logic                  resp_drop
);
    typedef enum logic [2:0] {IDLE, HDR, FETCH, LATCH, DATA} state_t;

    state_t                state, state_nxt;
    logic                  is_read;
    logic [7:0]            rma_id;
    logic [15:0]           elem_id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] len;
    logic [DATA_WIDTH-1:0] count;
    logic [DATA_WIDTH-1:0] byte_reg;
    logic [3:0]            idx;

    logic                  req;
    logic                  has_data;
    logic                  last_data;
    logic [15:0]           psize;
    logic [15:0]           addr16;
    logic [7:0]            hdr_byte;
    logic [DATA_WIDTH:0]   count_inc;

    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
    logic                  sop;
    logic                  eop;

    assign req       = send_write_resp | send_read_resp;
    assign has_data  = is_read && (len != '0);
    assign count_inc = {1'b0, count} + (DATA_WIDTH+1)'(1);
    assign last_data = (count_inc == {1'b0, len});
    assign psize     = 16'd12 + (is_read ? 16'(len) : 16'd0);
    assign addr16    = 16'(addr);
    assign busy      = (state != IDLE);

    always_comb begin
        case (idx)
            4'd0:    hdr_byte = 8'h10;
            4'd1:    hdr_byte = 8'h04;
            4'd2:    hdr_byte = psize[15:8];
            4'd3:    hdr_byte = psize[7:0];
            4'd4:    hdr_byte = rma_id;
            4'd5:    hdr_byte = is_read ? 8'h01 : 8'h11;
            4'd6:    hdr_byte = elem_id[15:8];
            4'd7:    hdr_byte = elem_id[7:0];
            4'd12:   hdr_byte = addr16[15:8];
            4'd13:   hdr_byte = addr16[7:0];
            4'd15:   hdr_byte = 8'(len);
            default: hdr_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        valid     = 1'b0;
        data      = '0;
        sop       = 1'b0;
        eop       = 1'b0;
        mem_oe    = 1'b0;
        mem_addr  = '0;
        case (state)
            IDLE: if (req) state_nxt = HDR;
            HDR: begin
                valid = 1'b1;
                data  = DATA_WIDTH'(hdr_byte);
                sop   = (idx == 4'd0);
                eop   = (idx == 4'd15) && !has_data;
                if (tx.tx_ready && idx == 4'd15) state_nxt = has_data ? FETCH : IDLE;
            end
            FETCH: begin
                mem_oe    = 1'b1;
                mem_addr  = addr + ADDR_WIDTH'(count);
                state_nxt = LATCH;
            end
            LATCH: state_nxt = DATA;
            DATA: begin
                valid = 1'b1;
                data  = byte_reg;
                eop   = last_data;
                if (tx.tx_ready) state_nxt = last_data ? IDLE : FETCH;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign tx.tx_valid = valid;
    assign tx.tx_data  = data;
    assign tx.tx_sop   = sop;
    assign tx.tx_eop   = eop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            is_read   <= 1'b0;
            rma_id    <= '0;
            elem_id   <= '0;
            addr      <= '0;
            len       <= '0;
            count     <= '0;
            byte_reg  <= '0;
            idx       <= '0;
            resp_drop <= 1'b0;
        end else begin
            // A read wins a same-cycle collision; the losing write is reported as dropped.
            resp_drop <= ((state != IDLE) && req) ||
                         ((state == IDLE) && send_write_resp && send_read_resp);
            case (state)
                IDLE: if (req) begin
                    is_read <= send_read_resp;
                    rma_id  <= resp_rma_id;
                    elem_id <= resp_elem_id;
                    addr    <= resp_addr;
                    len     <= resp_payload_len;
                    idx     <= '0;
                end
                HDR: if (tx.tx_ready) begin
                    idx   <= idx + 4'd1;
                    count <= '0;
                end
                LATCH: byte_reg <= mem_rdata;
                DATA:  if (tx.tx_ready) count <= count + DATA_WIDTH'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ecpri_tx_resp.sv
// Scoreboard bench: request stimulus pushes the expected frame and memory reads; negedge monitors pop and compare.
module tb_ecpri_tx_resp;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        send_write_resp = 1'b0;
    logic        send_read_resp = 1'b0;
    logic [7:0]  resp_payload_len = '0;
    logic [7:0]  resp_rma_id = '0;
    logic [15:0] resp_elem_id = '0;
    logic [15:0] resp_addr = '0;
    logic [15:0] mem_addr;
    logic        mem_oe;
    logic [7:0]  mem_rdata = '0;
    logic        busy;
    logic        resp_drop;

    ecpri_tx_resp_if #(.DATA_WIDTH(8)) tx_if ();

    ecpri_tx_resp #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .send_write_resp  (send_write_resp),
        .send_read_resp   (send_read_resp),
        .resp_payload_len (resp_payload_len),
        .resp_rma_id      (resp_rma_id),
        .resp_elem_id     (resp_elem_id),
        .resp_addr        (resp_addr),
        .mem_addr         (mem_addr),
        .mem_oe           (mem_oe),
        .mem_rdata        (mem_rdata),
        .tx               (tx_if),
        .busy             (busy),
        .resp_drop        (resp_drop)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:65535];
    logic [9:0]  exp_q [$];
    logic [15:0] addr_q [$];
    logic [7:0]  rx_log [$];
    int checks = 0, failures = 0;
    int drops_seen = 0, oe_seen = 0, byte_pos = 0;
    int ready_mode = 0;
    logic       held_vld = 1'b0;
    logic [10:0] held = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Reference model: the whole frame and its memory reads, straight from the frame layout rules.
    task automatic model_push(input bit rd, input logic [7:0] rma, input logic [15:0] elem,
                              input logic [15:0] a, input logic [7:0] len);
        logic [15:0] psize;
        logic [7:0]  h [16];
        logic [15:0] ra;
        bit          data_follows;
        psize = 16'd12 + (rd ? 16'(len) : 16'd0);
        h = '{8'h10, 8'h04, psize[15:8], psize[7:0], rma, (rd ? 8'h01 : 8'h11),
              elem[15:8], elem[7:0], 8'h00, 8'h00, 8'h00, 8'h00, a[15:8], a[7:0], 8'h00, len};
        data_follows = rd && (len != 0);
        for (int i = 0; i < 16; i++)
            exp_q.push_back({h[i], i == 0, (i == 15) && !data_follows});
        if (data_follows)
            for (int c = 0; c < int'(len); c++) begin
                ra = a + 16'(c);
                addr_q.push_back(ra);
                exp_q.push_back({mem[ra], 1'b0, c == int'(len) - 1});
            end
    endtask

    always @(posedge clk) if (mem_oe) mem_rdata <= mem[mem_addr];

    initial begin
        tx_if.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       tx_if.tx_ready = 1'b1;
                1:       tx_if.tx_ready = ~tx_if.tx_ready;
                default: tx_if.tx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(negedge clk) begin
        logic [9:0] got;
        if (!reset) begin
            held_vld = 1'b0;
        end else begin
            got = {tx_if.tx_data, tx_if.tx_sop, tx_if.tx_eop};
            if (held_vld) chk("stall_stable", {tx_if.tx_valid, got}, held);
            if (tx_if.tx_valid && tx_if.tx_ready) begin
                rx_log.push_back(tx_if.tx_data);
                if (exp_q.size() == 0) chk("unexpected_byte", {1'b1, got}, 11'h0);
                else                   chk("frame_byte", got, exp_q.pop_front());
                byte_pos = tx_if.tx_eop ? 0 : byte_pos + 1;
            end
            held_vld = tx_if.tx_valid && !tx_if.tx_ready;
            held     = {tx_if.tx_valid, got};
            if (mem_oe) begin
                oe_seen++;
                if (addr_q.size() == 0) chk("unexpected_mem_oe", 32'(mem_addr) | 32'h10000, 32'h0);
                else                    chk("mem_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
            end
            if (resp_drop) drops_seen++;
        end
    end

    task automatic request(input bit rd, input bit wr, input logic [7:0] rma, input logic [15:0] elem,
                           input logic [15:0] a, input logic [7:0] len);
        @(posedge clk);
        #1;
        resp_rma_id = rma; resp_elem_id = elem; resp_addr = a; resp_payload_len = len;
        send_read_resp = rd; send_write_resp = wr;
        model_push(rd, rma, elem, a, len);
        @(posedge clk);
        #1;
        send_read_resp = 1'b0; send_write_resp = 1'b0;
        chk("first_byte_latency", {30'd0, tx_if.tx_valid, tx_if.tx_sop}, 32'd3);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 5000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("frame_done_in_time", 32'(n < 5000), 32'd1);
        chk("mem_reads_outstanding", 32'(addr_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        #1;
    endtask

    initial begin
        int d0, o0, n;
        bit rd, wr;
        logic [7:0] len;
        logic [7:0] wr_vec [16];
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h0010] = 8'hA1; mem[16'h0011] = 8'hA2; mem[16'h0012] = 8'hA3;

        #12;
        chk("rst_tx_valid", 32'(tx_if.tx_valid), 0);
        chk("rst_sop_eop", {30'd0, tx_if.tx_sop, tx_if.tx_eop}, 0);
        chk("rst_tx_data", 32'(tx_if.tx_data), 0);
        chk("rst_busy_drop_oe", {29'd0, busy, resp_drop, mem_oe}, 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        @(negedge clk);
        reset = 1'b1;

        // Write response: exact byte vector.
        ready_mode = 0; rx_log.delete(); o0 = oe_seen;
        request(1'b0, 1'b1, 8'h5A, 16'h1234, 16'hBEEF, 8'd4);
        wait_done();
        wr_vec = '{8'h10, 8'h04, 8'h00, 8'h0C, 8'h5A, 8'h11, 8'h12, 8'h34,
                   8'h00, 8'h00, 8'h00, 8'h00, 8'hBE, 8'hEF, 8'h00, 8'h04};
        chk("wr_len", 32'(rx_log.size()), 16);
        for (int i = 0; i < 16 && i < rx_log.size(); i++) chk("wr_byte", 32'(rx_log[i]), 32'(wr_vec[i]));
        chk("wr_no_mem_oe", 32'(oe_seen - o0), 0);

        // Read response of three bytes.
        rx_log.delete();
        request(1'b1, 1'b0, 8'h21, 16'h0042, 16'h0010, 8'd3);
        wait_done();
        chk("rd_len", 32'(rx_log.size()), 19);
        if (rx_log.size() == 19) begin
            chk("rd_psize", {rx_log[2], rx_log[3]}, 32'h000F);
            chk("rd_type", 32'(rx_log[5]), 32'h01);
            chk("rd_data", {rx_log[16], rx_log[17], rx_log[18]}, 32'hA1A2A3);
        end

        // Backpressure.
        ready_mode = 1; o0 = oe_seen;
        request(1'b1, 1'b0, 8'h33, 16'hABCD, 16'h0200, 8'd2);
        wait_done();
        chk("bp_mem_oe_count", 32'(oe_seen - o0), 2);

        // Address wrap, then empty read.
        ready_mode = 0;
        request(1'b1, 1'b0, 8'h44, 16'h0001, 16'hFFFF, 8'd2);
        wait_done();
        rx_log.delete(); o0 = oe_seen;
        request(1'b1, 1'b0, 8'h45, 16'h0002, 16'h1000, 8'd0);
        wait_done();
        chk("empty_len", 32'(rx_log.size()), 16);
        if (rx_log.size() == 16) chk("empty_psize", {rx_log[2], rx_log[3]}, 32'h000C);
        chk("empty_no_oe", 32'(oe_seen - o0), 0);

        // Collision in the same cycle: read served, one drop.
        d0 = drops_seen;
        request(1'b1, 1'b1, 8'h66, 16'h0F0F, 16'h0300, 8'd1);
        wait_done();
        chk("collide_drop", 32'(drops_seen - d0), 1);

        // Second request while the header is going out.
        d0 = drops_seen;
        request(1'b1, 1'b0, 8'h77, 16'h7777, 16'h0400, 8'd2);
        @(posedge clk); #1;
        send_write_resp = 1'b1;
        @(posedge clk); #1;
        send_write_resp = 1'b0;
        wait_done();
        chk("busy_drop", 32'(drops_seen - d0), 1);

        // Reset at header byte 7.
        request(1'b0, 1'b1, 8'h88, 16'h8888, 16'h8888, 8'd0);
        n = 0;
        while (byte_pos != 7 && n < 100) begin @(negedge clk); #1; n++; end
        chk("reached_byte7", 32'(byte_pos), 7);
        reset = 1'b0;
        #1;
        chk("abort_tx_valid", 32'(tx_if.tx_valid), 0);
        chk("abort_no_eop", 32'(tx_if.tx_eop), 0);
        chk("abort_busy", 32'(busy), 0);
        exp_q.delete(); addr_q.delete(); byte_pos = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        rx_log.delete();
        request(1'b0, 1'b1, 8'h5A, 16'h1234, 16'hBEEF, 8'd4);
        wait_done();
        chk("post_reset_len", 32'(rx_log.size()), 16);

        // Randomized traffic.
        for (int k = 0; k < 24; k++) begin
            ready_mode = $urandom_range(0, 2);
            rd  = 1'($urandom_range(0, 1));
            wr  = !rd || ($urandom_range(0, 5) == 0);
            len = (k == 5) ? 8'd255 : 8'($urandom_range(0, 9));
            d0  = drops_seen;
            request(rd, wr, 8'($urandom), 16'($urandom), 16'($urandom), len);
            wait_done();
            chk("rand_drop", 32'(drops_seen - d0), 32'(rd && wr));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ecpri_tx_resp.md
# ecpri_tx_resp

Transmit-side response framer for the eCPRI Remote Memory Access (message type 4) path. It sits directly downstream of `ecpri_rx` and consumes its `send_write_resp` / `send_read_resp` / `resp_payload_len` outputs. For each request it emits one byte-wide response frame (4-byte common header, 12-byte RMA header, optional read data) on a ready/valid stream toward the MAC/TX FIFO. Read-response data is fetched from the shared register memory through a synchronous read port.

## Interface
- `DATA_WIDTH`, 8, byte lane width; also the width of the response length.
- `ADDR_WIDTH`, 16, memory address width.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `send_write_resp` input 1: one-cycle pulse from `ecpri_rx`; request a write response.
- `send_read_resp` input 1: one-cycle pulse from `ecpri_rx`; request a read response.
- `resp_payload_len` input DATA_WIDTH: number of data bytes accessed (0..255).
- `resp_rma_id` input 8: Remote Memory Access ID to echo.
- `resp_elem_id` input 16: Element ID to echo.
- `resp_addr` input ADDR_WIDTH: start address of the access.
- `mem_addr` output ADDR_WIDTH: memory read address.
- `mem_oe` output 1: memory read enable. Data is valid on `mem_rdata` the following cycle.
- `mem_rdata` input DATA_WIDTH: memory read data.
- `tx_data` output DATA_WIDTH: frame byte.
- `tx_valid` output 1: `tx_data` is valid.
- `tx_sop` / `tx_eop` output 1: first / last byte of the frame; qualified by `tx_valid`.
- `tx_ready` input 1: downstream accepts the byte when `tx_valid && tx_ready`.
- `busy` output 1: a frame is in progress.
- `resp_drop` output 1: one-cycle pulse when a request is discarded.

## Operation
- States: IDLE, HDR, FETCH, LATCH, DATA.
- **IDLE**
  - On a request pulse: latch `resp_rma_id`, `resp_elem_id`, `resp_addr`, `resp_payload_len` and the type (read/write). Set index=0 and go to HDR.
  - Read and write pulses in the same cycle: the read is served and `resp_drop` pulses.
- A request pulse in any state other than IDLE is ignored and `resp_drop` pulses.
- **HDR**: emits 16 bytes in order, index 0..15, all big-endian:
  - Bytes 0–1: 0x10 (revision 1, C=0), 0x04.
  - Bytes 2–3: payload size = 12 + (read ? len : 0), 16 bits.
  - Byte 4: rma_id.
  - Byte 5: 0x01 for a read response, 0x11 for a write response.
  - Bytes 6–7: elem_id.
  - Bytes 8–11: 0x00.
  - Bytes 12–13: addr[15:8], addr[7:0] (zero-extended when ADDR_WIDTH<16).
  - Bytes 14–15: 0x00, len.
- The index advances only when a byte is accepted. After byte 15 is accepted:
  - write response, or read with len=0: go to IDLE;
  - otherwise set count=0 and go to FETCH.
- **FETCH**: `mem_oe`=1, `mem_addr` = addr + count, wrapping modulo 2^ADDR_WIDTH. Go to LATCH.
- **LATCH**: capture `mem_rdata` into the byte register. Go to DATA.
- **DATA**: `tx_data` = byte register. When the byte is accepted, increment count, then go to FETCH if count < len, else IDLE.
- `tx_sop` is asserted only on header byte 0.
- `tx_eop` is asserted on the final byte: header byte 15 when there is no data, else the data byte with count = len-1.
- `busy` = state != IDLE.

## Timing
- Reset values: all outputs 0; state IDLE. Reset asserted mid-frame aborts at once: `tx_valid` falls asynchronously and no `tx_eop` is sent.
- A request sampled at edge T gives `tx_valid`=1 with byte 0 from cycle T+1.
- Header throughput: 1 byte/cycle while `tx_ready`=1.
- Data throughput: 1 byte per 3 cycles (FETCH, LATCH, DATA) with no stall.
- While `tx_valid`=1 and `tx_ready`=0: `tx_data`, `tx_sop` and `tx_eop` hold stable.
- `mem_oe` is asserted for exactly one cycle per data byte; the same address is never read twice.
- Return to IDLE occurs on the edge that accepts the eop byte. A request in the next cycle is accepted without a drop.

## Test plan
- **Write response**: rma_id=0x5A, elem_id=0x1234, addr=0xBEEF, len=4, tx_ready=1.
  - Required: 16 bytes `10 04 00 0C 5A 11 12 34 00 00 00 00 BE EF 00 04`, sop on the first byte, eop on the 16th, no `mem_oe`.
- **Read response**: len=3, addr=0x0010, memory holds 0xA1/0xA2/0xA3 at 0x10–0x12.
  - Required: header payload size 0x000F, byte 5 = 0x01.
  - Required: data A1 A2 A3 read from addresses 0x10, 0x11, 0x12; eop on A3.
- **Backpressure**: read len=2 with `tx_ready` toggling every cycle.
  - Required: identical byte sequence to the unstalled case, outputs stable while stalled, exactly 2 `mem_oe` pulses.
- **Wrap and empty read**:
  - Read len=2 at addr=0xFFFF: required reads at 0xFFFF, then 0x0000.
  - Read len=0: required 16 bytes only, eop on byte 15, payload size 0x000C.
- **Collisions**:
  - Read and write pulses in the same cycle: required read frame, `resp_drop`=1 for one cycle.
  - Second request during the HDR state: required `resp_drop` pulse and the frame unchanged.
- **Reset mid-frame**: reset asserted at header byte 7.
  - Required: `tx_valid`=0 immediately, no eop.
  - After release, a new write request produces a complete, correct frame.
